// File: rtl/cpu13_pkg.sv
// Shared definitions for the 13-bit teaching CPU: instruction fields, opcodes,
// sequencer states and the immediate sign-extension helpers.
package cpu13_pkg;

  localparam int DATA_W = 13;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUBI = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;
  localparam logic [2:0] OP_FP0  = 3'b110;
  localparam logic [2:0] OP_FP1  = 3'b111;

  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 10;
  localparam int R1_MSB  = 9;
  localparam int R1_LSB  = 7;
  localparam int R2_MSB  = 6;
  localparam int R2_LSB  = 4;
  localparam int R3_MSB  = 3;
  localparam int R3_LSB  = 1;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK
  } state_e;

  function automatic logic [DATA_W-1:0] sext4(input logic [3:0] v);
    return {{(DATA_W-4){v[3]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext3(input logic [2:0] v);
    return {{(DATA_W-3){v[2]}}, v};
  endfunction

endpackage

// File: rtl/cpu13_alu.sv
// Combinational ALU for the 13-bit CPU. MUL/ASR on opcodes 11x exist only when
// CPU13_EXT_ARITH_EN is defined; otherwise those opcodes produce zero.
module cpu13_alu
  import cpu13_pkg::*;
(
  input  logic [2:0]        alu_op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              eq_o
);

`ifdef CPU13_EXT_ARITH_EN
  // Low product bits are identical for signed and unsigned operands.
  logic [DATA_W-1:0] mul_lo;
  assign mul_lo = a_i * b_i;
`endif

  always_comb begin
    result_o = '0;
    case (alu_op_i)
      OP_ADD, OP_ADDI: result_o = a_i + b_i;
      OP_SUB, OP_SUBI: result_o = a_i - b_i;
`ifdef CPU13_EXT_ARITH_EN
      OP_FP0:          result_o = mul_lo;
      OP_FP1:          result_o = $signed(a_i) >>> b_i[3:0];
`endif
      default:         result_o = '0;
    endcase
  end

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/cpu13_exec_ctrl.sv
// Fetch/decode/execute/writeback sequencer for the 13-bit CPU.
// Define CPU13_EXT_ARITH_EN to enable MUL/ASR; otherwise opcodes 11x retire as illegal NOPs.
module cpu13_exec_ctrl
  import cpu13_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_done_i,
  output logic [DATA_W-1:0] pc_o,
  output logic              mem_read_o,
  output logic              mem_instr_o,
  output logic [2:0]        reg_rd_addr2_o,
  output logic [2:0]        reg_rd_addr3_o,
  input  logic [DATA_W-1:0] reg_rdata2_i,
  input  logic [DATA_W-1:0] reg_rdata3_i,
  output logic [2:0]        reg_wr_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_write_o,
  output logic              alu_eq_o,
  output logic              illegal_o
);

`ifdef CPU13_EXT_ARITH_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif

  state_e            state_q;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] result_q;
  logic              alu_eq_q, alu_eq_d;

  logic [2:0]        op;
  logic              is_imm, is_branch, is_ext, writes_rf, taken;
  logic [DATA_W-1:0] alu_b, alu_result;
  logic              alu_eq_w;

  assign op        = ir_q[OP_MSB:OP_LSB];
  assign is_imm    = (op == OP_ADDI) || (op == OP_SUBI);
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign is_ext    = (op == OP_FP0) || (op == OP_FP1);
  assign writes_rf = !op[2] || (is_ext && EXT_EN);

  assign alu_b = is_imm ? sext4(ir_q[IMM_MSB:IMM_LSB]) : reg_rdata3_i;

  cpu13_alu u_alu (
    .alu_op_i (op),
    .a_i      (reg_rdata2_i),
    .b_i      (alu_b),
    .result_o (alu_result),
    .eq_o     (alu_eq_w)
  );

  // The compare flag always reflects R2 == R3, even when the ALU sees the immediate.
  assign alu_eq_d = is_imm ? (reg_rdata2_i == reg_rdata3_i) : alu_eq_w;

  // BEQ uses variant bit 0, BNE variant bit 1, so taken is eq XOR op[0].
  assign taken = is_branch && (alu_eq_q ^ op[0]);
  assign pc_d  = pc_q + DATA_W'(1) + (taken ? sext3(ir_q[R1_MSB:R1_LSB]) : '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      result_q <= '0;
      alu_eq_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem_done_i) begin
            ir_q    <= mem_rdata_i;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE:  state_q <= ST_EXECUTE;
        ST_EXECUTE: begin
          result_q <= alu_result;
          alu_eq_q <= alu_eq_d;
          state_q  <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          pc_q    <= pc_d;
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Strobes are gated by reset so nothing is requested or written during a reset cycle.
  assign mem_read_o  = (state_q == ST_FETCH) && !reset_i;
  assign mem_instr_o = (state_q == ST_FETCH) && !reset_i;
  assign reg_write_o = (state_q == ST_WRITEBACK) && writes_rf && !reset_i;
  assign illegal_o   = (state_q == ST_WRITEBACK) && is_ext && !EXT_EN && !reset_i;

  assign pc_o           = pc_q;
  assign reg_rd_addr2_o = ir_q[R2_MSB:R2_LSB];
  assign reg_rd_addr3_o = ir_q[R3_MSB:R3_LSB];
  assign reg_wr_addr_o  = ir_q[R1_MSB:R1_LSB];
  assign reg_wdata_o    = result_q;
  assign alu_eq_o       = alu_eq_q;

endmodule

// File: tb/tb_cpu13_exec_ctrl.sv
// Testbench for cpu13_exec_ctrl: bench acts as memory and register file, predicts each
// instruction's writeback and next PC, and compares at WRITEBACK (honours CPU13_EXT_ARITH_EN).
module tb_cpu13_exec_ctrl;

  logic        clk;
  logic        reset;
  logic [12:0] memRdata;
  logic        memDone;
  logic [12:0] pc;
  logic        memRead, memInstr;
  logic [2:0]  rdAddr2, rdAddr3, wrAddr;
  logic [12:0] rdata2, rdata3, wdata;
  logic        regWrite, aluEq, illegal;

  logic [12:0] regs [8];
  logic [12:0] expPc;
  int          checkCount = 0;
  int          passCount  = 0;

  typedef struct packed {
    logic        wr;
    logic [12:0] wdata;
    logic [12:0] nextPc;
    logic        ill;
    logic        eq;
    logic [2:0]  a2;
    logic [2:0]  a3;
    logic [2:0]  wa;
  } expect_t;

  expect_t sb [$];

  cpu13_exec_ctrl dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .mem_rdata_i    (memRdata),
    .mem_done_i     (memDone),
    .pc_o           (pc),
    .mem_read_o     (memRead),
    .mem_instr_o    (memInstr),
    .reg_rd_addr2_o (rdAddr2),
    .reg_rd_addr3_o (rdAddr3),
    .reg_rdata2_i   (rdata2),
    .reg_rdata3_i   (rdata3),
    .reg_wr_addr_o  (wrAddr),
    .reg_wdata_o    (wdata),
    .reg_write_o    (regWrite),
    .alu_eq_o       (aluEq),
    .illegal_o      (illegal)
  );

  assign rdata2 = regs[rdAddr2];
  assign rdata3 = regs[rdAddr3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // Reference model of one instruction, from field values and operand contents.
  function automatic expect_t predict(input logic [12:0] instr, input logic [12:0] curPc,
                                      input logic [12:0] a, input logic [12:0] b);
    expect_t     e;
    logic [12:0] imm, off;
    logic signed [25:0] prod;
    imm = {{9{instr[3]}}, instr[3:0]};
    off = {{10{instr[9]}}, instr[9:7]};
    e.wr = 1'b1;
    e.wdata = '0;
    e.ill = 1'b0;
    e.eq = (a == b);
    e.nextPc = curPc + 13'd1;
    e.a2 = instr[6:4];
    e.a3 = instr[3:1];
    e.wa = instr[9:7];
    prod = $signed(a) * $signed(b);
    case (instr[12:10])
      3'b000: e.wdata = a + b;
      3'b001: e.wdata = a - b;
      3'b010: e.wdata = a + imm;
      3'b011: e.wdata = a - imm;
      3'b100: begin e.wr = 1'b0; if (a == b) e.nextPc = curPc + 13'd1 + off; end
      3'b101: begin e.wr = 1'b0; if (a != b) e.nextPc = curPc + 13'd1 + off; end
`ifdef CPU13_EXT_ARITH_EN
      3'b110: e.wdata = prod[12:0];
      default: e.wdata = 13'($signed(a) >>> b[3:0]);
`else
      default: begin e.wr = 1'b0; e.ill = 1'b1; end
`endif
    endcase
    return e;
  endfunction

  // Runs one instruction from a FETCH-cycle negedge to the next FETCH-cycle negedge.
  task automatic applyStimulus(input logic [12:0] instr, input int stall);
    expect_t e;
    #1;
    checkOutput("fetchPc", 32'(pc), 32'(expPc));
    checkOutput("fetchRead", 32'(memRead), 32'd1);
    checkOutput("fetchInstr", 32'(memInstr), 32'd1);
    checkOutput("fetchNoWrite", 32'(regWrite), 32'd0);
    sb.push_back(predict(instr, expPc, regs[instr[6:4]], regs[instr[3:1]]));
    for (int i = 0; i < stall; i++) begin
      memDone = 1'b0;
      memRdata = 13'($urandom);
      @(negedge clk);
      checkOutput("stallRead", 32'(memRead), 32'd1);
      checkOutput("stallPc", 32'(pc), 32'(expPc));
    end
    memDone = 1'b1;
    memRdata = instr;
    @(negedge clk);
    memRdata = 13'($urandom);
    checkOutput("decodeRead", 32'(memRead), 32'd0);
    @(negedge clk);
    memDone = 1'b0;
    checkOutput("execNoWrite", 32'(regWrite), 32'd0);
    @(negedge clk);
    if (sb.size() == 0) begin
      checkOutput("sbUnderflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("rdAddr2", 32'(rdAddr2), 32'(e.a2));
      checkOutput("rdAddr3", 32'(rdAddr3), 32'(e.a3));
      checkOutput("wrAddr", 32'(wrAddr), 32'(e.wa));
      checkOutput("wbWrite", 32'(regWrite), 32'(e.wr));
      if (e.wr) checkOutput("wbData", 32'(wdata), 32'(e.wdata));
      checkOutput("wbIllegal", 32'(illegal), 32'(e.ill));
      checkOutput("wbAluEq", 32'(aluEq), 32'(e.eq));
      checkOutput("wbPcHeld", 32'(pc), 32'(expPc));
      if (regWrite) regs[wrAddr] = wdata;
      @(negedge clk);
      checkOutput("nextPc", 32'(pc), 32'(e.nextPc));
      checkOutput("illegalPulse", 32'(illegal), 32'd0);
      expPc = e.nextPc;
    end
  endtask

  initial begin
    reset = 1'b1;
    memDone = 1'b0;
    memRdata = '0;
    expPc = '0;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstPc", 32'(pc), 32'd0);
    checkOutput("rstRead", 32'(memRead), 32'd0);
    checkOutput("rstInstr", 32'(memInstr), 32'd0);
    checkOutput("rstWrite", 32'(regWrite), 32'd0);
    checkOutput("rstAluEq", 32'(aluEq), 32'd0);
    checkOutput("rstWdata", 32'(wdata), 32'd0);
    reset = 1'b0;

    // ADD R5,R6,R7 at pc 0
    regs[6] = 13'd6; regs[7] = 13'd4;
    applyStimulus(13'b0001011101110, 0);
    // ADDI / SUBI with imm -6
    regs[2] = 13'd3;
    applyStimulus(13'b0100010101010, 0);
    regs[2] = 13'd3;
    applyStimulus(13'b0110010101010, 2);
    // ADD wrapping 0x1FFF + 1, stalled five cycles
    regs[1] = 13'h1FFF; regs[2] = 13'd1;
    applyStimulus(13'b0000000010100, 5);
    // BEQ R1=3 at pc 4: taken then not taken
    regs[5] = 13'd7; regs[7] = 13'd7;
    applyStimulus(13'b1000111011110, 0);
    regs[7] = 13'd8;
    applyStimulus(13'b1000111011110, 0);
    // BNE R1=-1, taken
    applyStimulus(13'b1011111011110, 0);
    // SUB
    regs[3] = 13'd5; regs[4] = 13'd9;
    applyStimulus(13'b0010100110000 | 13'b0000000001000, 0);
    // op 110 with 3 * 5, then op 111 with negative value shifted by 14 and by 2
    regs[1] = 13'd3; regs[2] = 13'd5;
    applyStimulus(13'b1100000010100, 0);
    regs[3] = 13'h1F00; regs[4] = 13'd14;
    applyStimulus(13'b1110010111000, 0);
    regs[3] = 13'h10F0; regs[4] = 13'd2;
    applyStimulus(13'b1110010111000, 0);

    // Reset arriving during EXECUTE must suppress the writeback
    regs[6] = 13'd1; regs[7] = 13'd1;
    memDone = 1'b1;
    memRdata = 13'b0001011101110;
    @(negedge clk);
    memDone = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstWrite", 32'(regWrite), 32'd0);
    checkOutput("midRstRead", 32'(memRead), 32'd0);
    checkOutput("midRstPc", 32'(pc), 32'd0);
    reset = 1'b0;
    expPc = '0;

    // BEQ R1=-2 at pc 0 wraps to 8191, then ADD wraps pc to 0
    regs[5] = 13'd2; regs[7] = 13'd2;
    applyStimulus(13'b1001101011110, 0);
    checkOutput("wrapTarget", 32'(expPc), 32'h1FFF);
    regs[6] = 13'd2; regs[7] = 13'd3;
    applyStimulus(13'b0001011101110, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
